fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: one outstanding imem read, redirect handling, decode handoff
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] pc_next,
  output logic             pc_en,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_instr,
  output logic [WIDTH-1:0] if_pc,
  input  logic             dec_ready
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DROP} state_t;

  state_t state_q, state_d;
  logic   transfer;
  logic   capture;

  assign imem_addr = {pc_in[WIDTH-1:2], 2'b00};
  assign transfer  = (state_q == HOLD) && if_valid && dec_ready && !redirect_valid;

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    capture  = 1'b0;
    pc_en    = 1'b0;
    pc_next  = pc_in;
    case (state_q)
      FETCH: begin
        if (!redirect_valid) begin
          imem_req = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          state_d = imem_rvalid ? FETCH : DROP;
        end else if (imem_rvalid) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid || transfer) state_d = FETCH;
      end
      DROP: begin
        // the outstanding response retires the drop even if another redirect arrives with it
        if (imem_rvalid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (redirect_valid) begin
      pc_en   = 1'b1;
      pc_next = redirect_pc;
    end else if (transfer) begin
      pc_en   = 1'b1;
      pc_next = if_pc + WIDTH'(4);
    end
    // reset must silence the combinational controls without waiting for a clock
    if (rst) begin
      imem_req = 1'b0;
      pc_en    = 1'b0;
      pc_next  = pc_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= RESET_PC;
    end else begin
      state_q <= state_d;
      if (capture) begin
        if_valid <= 1'b1;
        if_instr <= imem_rdata;
        if_pc    <= pc_in;
      end else if (redirect_valid || transfer) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit against a transaction-level fetch model
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, pc_next, imem_addr, imem_rdata, redirect_pc, if_instr, if_pc;
  logic        pc_en, imem_req, imem_rvalid, redirect_valid, if_valid, dec_ready;

  always #5 clk = ~clk;

  fetch_unit #(.WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_next(pc_next), .pc_en(pc_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .dec_ready(dec_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // model: an instruction held for decode, a request in flight, and whether its data is unwanted
  bit          m_valid, m_pending, m_discard;
  logic [31:0] m_instr, m_pc, pc_reg;
  // memory: one response slot, latency 1..3 cycles after the request
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_data;

  bit          do_rst, exp_req, xfer, exp_pc_en;
  logic [31:0] exp_pc_next;
  int          hold_resets = 0;

  task automatic model_reset();
    m_valid   = 1'b0;
    m_pending = 1'b0;
    m_discard = 1'b0;
    m_instr   = '0;
    m_pc      = RESET_PC;
    pc_reg    = RESET_PC;
  endtask

  initial begin
    rst = 1'b0; pc_in = RESET_PC; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
    mem_busy = 1'b0; mem_cnt = 0; mem_data = '0;
    model_reset();
    #1 rst = 1'b1;
    #1;
    check_eq("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check_eq("rst_if_pc", if_pc, RESET_PC);
    check_eq("rst_if_instr", if_instr, 32'd0);
    check_eq("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check_eq("rst_pc_en", {31'b0, pc_en}, 32'd0);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      do_rst = (cyc < 3) || ($urandom_range(0, 149) == 0) ||
               (hold_resets == 0 && cyc > 500 && m_valid);

      // memory side: deliver the scheduled response, or occasionally a stray one
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (mem_busy) begin
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_data;
          mem_busy    = 1'b0;
        end else begin
          mem_cnt--;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        imem_rvalid = 1'b1;
      end

      redirect_valid = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0: redirect_pc = $urandom;
        1: redirect_pc = 32'hFFFF_FFFC;
        2: redirect_pc = 32'h0000_3002;
        default: redirect_pc = 32'h0000_3100;
      endcase
      if ($urandom_range(0, 3) == 0) dec_ready = $urandom_range(0, 1);

      if (do_rst) begin
        if (m_valid) hold_resets++;
        model_reset();
        rst = 1'b1;
      end else begin
        rst = 1'b0;
      end
      pc_in = pc_reg;
      #1;

      if (do_rst) begin
        check_eq("rst_if_valid", {31'b0, if_valid}, 32'd0);
        check_eq("rst_if_pc", if_pc, RESET_PC);
        check_eq("rst_if_instr", if_instr, 32'd0);
        check_eq("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check_eq("rst_pc_en", {31'b0, pc_en}, 32'd0);
      end else begin
        exp_req     = !m_valid && !m_pending && !redirect_valid;
        xfer        = m_valid && dec_ready && !redirect_valid;
        exp_pc_en   = redirect_valid || xfer;
        exp_pc_next = redirect_valid ? redirect_pc : (xfer ? m_pc + 32'd4 : pc_reg);
        check_eq("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        check_eq("imem_addr", imem_addr, pc_reg & 32'hFFFF_FFFC);
        check_eq("pc_en", {31'b0, pc_en}, {31'b0, exp_pc_en});
        check_eq("pc_next", pc_next, exp_pc_next);
        check_eq("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
        if (m_valid) begin
          check_eq("if_instr", if_instr, m_instr);
          check_eq("if_pc", if_pc, m_pc);
        end

        if (m_pending && imem_rvalid) begin
          if (!m_discard && !redirect_valid) begin
            m_valid = 1'b1;
            m_instr = imem_rdata;
            m_pc    = pc_reg;
          end
          m_pending = 1'b0;
          m_discard = 1'b0;
        end else if (m_pending && redirect_valid) begin
          m_discard = 1'b1;
        end
        if (m_valid && (redirect_valid || xfer) && !(m_pending)) m_valid = xfer || redirect_valid ? 1'b0 : m_valid;
        if (exp_req) begin
          m_pending = 1'b1;
          mem_busy  = 1'b1;
          mem_cnt   = $urandom_range(0, 2);
          mem_data  = $urandom;
        end
        if (exp_pc_en) pc_reg = exp_pc_next;
      end
    end

    check_eq("hold_reset_seen", {31'b0, (hold_resets > 0)}, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
